clkdiv_monitor: RTL and testbench



---
 rtl/clkdiv_pkg.sv | 27 ++
 rtl/clkdiv_edge_det.sv | 26 ++
 rtl/clkdiv_monitor.sv | 155 +++++++++++++++
 tb/tb_clkdiv_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Holds the FSM state encoding, default expectations and a no-wrap absolute difference.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

  localparam int unsigned DEF_EXP_PERIOD = 3;
  localparam int unsigned DEF_EXP_HIGH   = 2;
  localparam int unsigned DEF_TOL        = 0;

  // Widest counter this checker may be built with; abs_diff works at this width.
  localparam int unsigned CNT_W_MAX = 16;
  localparam int unsigned RUN_W     = 4;

  // One extra signed bit keeps the subtraction from wrapping for any operand pair.
  function automatic logic [CNT_W_MAX-1:0] abs_diff(input logic [CNT_W_MAX-1:0] a,
                                                    input logic [CNT_W_MAX-1:0] b);
    logic signed [CNT_W_MAX:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return diff[CNT_W_MAX] ? CNT_W_MAX'(-diff) : CNT_W_MAX'(diff);
  endfunction

endpackage

// File: rtl/clkdiv_edge_det.sv
// Single-flop edge detector for a clk-domain signal.
// Rise and fall are combinational from the current sample and the previous one.
module clkdiv_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;
  assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/clkdiv_monitor.sv
// Measures period and high time of a divided clock sampled in the clk domain,
// qualifies each period against expectations and reports lock, error and stuck.
module clkdiv_monitor
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned EXP_HIGH   = DEF_EXP_HIGH,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_div_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_hcnt;
  logic [CNT_W-1:0]   r_wait;
  logic [RUN_W-1:0]   r_run;

  logic               w_rise;
  logic               w_fall_unused;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_hcnt_inc;
  logic [RUN_W-1:0]   w_run_inc;
  logic [CNT_W_MAX-1:0] w_per_dev;
  logic [CNT_W_MAX-1:0] w_high_dev;
  logic               w_good;
  logic               w_meas_timeout;
  logic               w_sync_timeout;

  clkdiv_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (clk_div_in),
    .o_rise (w_rise),
    .o_fall (w_fall_unused)
  );

  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_hcnt_inc = (clk_div_in && (r_hcnt != CNT_MAX)) ? r_hcnt + CNT_W'(1) : r_hcnt;
  assign w_run_inc  = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);

  assign w_per_dev  = abs_diff(CNT_W_MAX'(r_cnt), CNT_W_MAX'(EXP_PERIOD));
  assign w_high_dev = abs_diff(CNT_W_MAX'(r_hcnt), CNT_W_MAX'(EXP_HIGH));
  assign w_good     = (w_per_dev <= CNT_W_MAX'(TOL)) && (w_high_dev <= CNT_W_MAX'(TOL));

  assign w_meas_timeout = (r_cnt == CNT_W'(TIMEOUT));
  assign w_sync_timeout = (r_wait == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_wait     <= '0;
      r_run      <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // NOTE: a later assignment in this block overrides this clear, so a bad
      // measurement in the same cycle leaves err set.
      if (err_clr) begin
        err <= 1'b0;
      end

      if (!en) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
        r_wait  <= '0;
        r_run   <= '0;
        locked  <= 1'b0;
        stuck   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_SYNC;
            r_wait  <= '0;
          end

          // The first rise only aligns the counters; that partial period is never published.
          ST_SYNC: begin
            if (w_rise) begin
              r_cnt   <= CNT_W'(1);
              r_hcnt  <= CNT_W'(1);
              stuck   <= 1'b0;
              r_state <= ST_MEAS;
            end else if (w_sync_timeout) begin
              stuck <= 1'b1;
            end else begin
              r_wait <= r_wait + CNT_W'(1);
            end
          end

          ST_MEAS: begin
            if (w_rise) begin
              period     <= r_cnt;
              high_time  <= r_hcnt;
              meas_valid <= 1'b1;
              r_cnt      <= CNT_W'(1);
              r_hcnt     <= CNT_W'(1);
              stuck      <= 1'b0;
              if (w_good) begin
                r_run <= w_run_inc;
                if (w_run_inc >= RUN_W'(LOCK_CNT)) begin
                  locked <= 1'b1;
                end
              end else begin
                r_run  <= '0;
                locked <= 1'b0;
                err    <= 1'b1;
              end
            end else if (w_meas_timeout) begin
              stuck   <= 1'b1;
              locked  <= 1'b0;
              r_run   <= '0;
              r_cnt   <= '0;
              r_hcnt  <= '0;
              r_wait  <= '0;
              r_state <= ST_SYNC;
            end else begin
              r_cnt  <= w_cnt_inc;
              r_hcnt <= w_hcnt_inc;
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Bench for clkdiv_monitor: two instances (tolerance 0 and 1, timeout 20) share one
// stimulus stream and are compared every cycle against an event-level reference model.
module tb_clkdiv_monitor;

  localparam int TO      = 20;
  localparam int EXP_P   = 3;
  localparam int EXP_H   = 2;
  localparam int LOCK_N  = 4;
  localparam int SAT_MAX = 255;

  logic clk = 1'b0;
  logic rst, en, d, clr;

  logic [7:0] a_period, a_high, b_period, b_high;
  logic       a_mv, a_lk, a_er, a_st, b_mv, b_lk, b_er, b_st;

  always #5 clk = ~clk;

  clkdiv_monitor #(.CNT_W(8), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(0),
                   .LOCK_CNT(LOCK_N), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clk_div_in(d), .err_clr(clr),
    .period(a_period), .high_time(a_high), .meas_valid(a_mv),
    .locked(a_lk), .err(a_er), .stuck(a_st)
  );

  clkdiv_monitor #(.CNT_W(8), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(1),
                   .LOCK_CNT(LOCK_N), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clk_div_in(d), .err_clr(clr),
    .period(b_period), .high_time(b_high), .meas_valid(b_mv),
    .locked(b_lk), .err(b_er), .stuck(b_st)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in absolute cycle numbers: a period is the distance between two rises,
  // high time is the count of high samples since the last rise.
  int      m_tol [2] = '{0, 1};
  bit      m_prev[2], m_mv[2], m_locked[2], m_err[2], m_stuck[2], m_active[2];
  int      m_period[2], m_high_time[2], m_high[2], m_run[2];
  longint  m_last_rise[2], m_wait_from[2];
  longint  cyc_n = 0;
  bit      model_ok = 1'b0;

  function automatic int absd(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  task automatic model_step(input int k);
    bit     rise;
    longint el;
    rise      = d && !m_prev[k];
    m_prev[k] = d;
    m_mv[k]   = 1'b0;
    if (rst) begin
      m_prev[k] = 0; m_period[k] = 0; m_high_time[k] = 0; m_locked[k] = 0;
      m_err[k] = 0; m_stuck[k] = 0; m_active[k] = 0; m_last_rise[k] = -1; m_run[k] = 0;
      return;
    end
    if (clr) m_err[k] = 1'b0;
    if (!en) begin
      m_active[k] = 0; m_last_rise[k] = -1; m_run[k] = 0; m_locked[k] = 0; m_stuck[k] = 0;
    end else if (!m_active[k]) begin
      m_active[k]    = 1;
      m_wait_from[k] = cyc_n;
    end else if (m_last_rise[k] < 0) begin
      if (rise) begin
        m_last_rise[k] = cyc_n; m_high[k] = 1; m_stuck[k] = 0;
      end else if (cyc_n - m_wait_from[k] >= TO) begin
        m_stuck[k] = 1;
      end
    end else begin
      el = cyc_n - m_last_rise[k];
      if (el > SAT_MAX) el = SAT_MAX;
      if (rise) begin
        m_period[k] = int'(el); m_high_time[k] = m_high[k]; m_mv[k] = 1;
        if (absd(int'(el), EXP_P) <= m_tol[k] && absd(m_high[k], EXP_H) <= m_tol[k]) begin
          m_run[k] = (m_run[k] < 15) ? m_run[k] + 1 : 15;
          if (m_run[k] >= LOCK_N) m_locked[k] = 1;
        end else begin
          m_run[k] = 0; m_locked[k] = 0; m_err[k] = 1;
        end
        m_last_rise[k] = cyc_n; m_high[k] = 1; m_stuck[k] = 0;
      end else if (el == TO) begin
        m_stuck[k] = 1; m_locked[k] = 0; m_run[k] = 0;
        m_last_rise[k] = -1; m_wait_from[k] = cyc_n;
      end else begin
        m_high[k] += int'(d);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc_n++;
    for (int k = 0; k < 2; k++) model_step(k);
    if (rst) model_ok = 1'b1;
  end

  // One compare process, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("a.period",     a_period, m_period[0]);
      check("a.high_time",  a_high,   m_high_time[0]);
      check("a.meas_valid", a_mv,     m_mv[0]);
      check("a.locked",     a_lk,     m_locked[0]);
      check("a.err",        a_er,     m_err[0]);
      check("a.stuck",      a_st,     m_stuck[0]);
      check("b.period",     b_period, m_period[1]);
      check("b.high_time",  b_high,   m_high_time[1]);
      check("b.meas_valid", b_mv,     m_mv[1]);
      check("b.locked",     b_lk,     m_locked[1]);
      check("b.err",        b_er,     m_err[1]);
      check("b.stuck",      b_st,     m_stuck[1]);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] sa_p, sa_ht;
  logic       sa_mv, sa_lk, sa_er, sa_st, sb_lk, sb_er;

  task automatic cyc(input bit v);
    d = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One divided-clock period; outputs are captured right after the rise cycle.
  task automatic per(input int h, input int l, input bit c);
    clr = c;
    cyc(1'b1);
    clr = 1'b0;
    sa_p = a_period; sa_ht = a_high; sa_mv = a_mv; sa_lk = a_lk; sa_er = a_er; sa_st = a_st;
    sb_lk = b_lk; sb_er = b_er;
    repeat (h - 1) cyc(1'b1);
    repeat (l) cyc(1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; d = 1'b0; clr = 1'b0;
    repeat (3) cyc(1'b0);
    check("rst_period", a_period, 0);
    check("rst_high",   a_high,   0);
    check("rst_flags",  {a_mv, a_lk, a_er, a_st}, 4'b0000);

    rst = 1'b0;
    cyc(1'b0);
    per(2, 1, 0); check("r1_no_publish", sa_mv, 0);
    per(2, 1, 0); check("r2_mv", sa_mv, 1); check("r2_period", sa_p, 3); check("r2_high", sa_ht, 2);
    per(2, 1, 0); per(2, 1, 0); check("r4_unlocked", sa_lk, 0);
    per(2, 1, 0); check("r5_locked", sa_lk, 1); check("r5_err", sa_er, 0);

    per(2, 2, 0);
    per(2, 1, 0);
    check("bad_mv", sa_mv, 1); check("bad_period", sa_p, 4); check("bad_high", sa_ht, 2);
    check("bad_unlock", sa_lk, 0); check("bad_err", sa_er, 1);
    per(2, 1, 0); per(2, 1, 0); per(2, 1, 0);
    check("err_sticky", sa_er, 1); check("relock_not_yet", sa_lk, 0);
    per(2, 1, 0); check("relock", sa_lk, 1);

    per(2, 2, 0);
    per(2, 1, 1); check("clr_collide_err", sa_er, 1);
    per(2, 1, 1); check("clr_err", sa_er, 0);
    per(2, 1, 0); per(2, 1, 0); per(2, 1, 0); check("lock_before_stuck", sa_lk, 1);

    repeat (17) cyc(1'b0);
    check("stuck_not_yet", a_st, 0); check("locked_before_to", a_lk, 1);
    cyc(1'b0);
    check("stuck_set", a_st, 1); check("stuck_unlock", a_lk, 0);
    per(2, 1, 0); check("stuck_cleared", sa_st, 0); check("stuck_rise_no_pub", sa_mv, 0);
    per(2, 1, 0); per(2, 1, 0); per(2, 1, 0); per(2, 1, 0); check("lock_after_stuck", sa_lk, 1);

    cyc(1'b1);
    en = 1'b0;
    cyc(1'b1);
    check("dis_unlock", a_lk, 0); check("dis_mv", a_mv, 0); check("dis_period_hold", a_period, 3);
    cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    check("dis_no_pub", a_mv, 0);
    en = 1'b1;
    cyc(1'b0);
    per(2, 1, 0); check("reen_r1_no_pub", sa_mv, 0);
    per(2, 1, 0); check("reen_r2_mv", sa_mv, 1); check("reen_r2_period", sa_p, 3);

    en = 1'b0; cyc(1'b0); en = 1'b1;
    repeat (20) cyc(1'b0);
    check("sync_stuck_not_yet", a_st, 0);
    cyc(1'b0);
    check("sync_stuck_set", a_st, 1);

    per(2, 1, 0); per(2, 2, 0); per(2, 1, 0); per(2, 2, 0);
    check("tol_r4_unlocked", sb_lk, 0);
    per(2, 1, 0);
    check("tol_locked", sb_lk, 1); check("tol_err", sb_er, 0);
    check("tol0_err", sa_er, 1); check("tol0_unlocked", sa_lk, 0);

    cyc(1'b1);
    rst = 1'b1;
    cyc(1'b1);
    check("rst_mid_a", {a_period, a_high, a_mv, a_lk, a_er, a_st}, 20'h0);
    check("rst_mid_b", {b_period, b_high, b_mv, b_lk, b_er, b_st}, 20'h0);
    rst = 1'b0;

    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1; cyc(1'($urandom_range(0, 1))); rst = 1'b0;
      end else if (r < 7) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) cyc(1'($urandom_range(0, 1)));
        en = 1'b1;
      end else if (r < 13) begin
        bit v;
        v = 1'($urandom_range(0, 1));
        repeat ($urandom_range(15, 45)) cyc(v);
      end else begin
        per(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), ($urandom_range(0, 9) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
